// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
package regfile_pkg;

    typedef enum logic {INIT, RUN} rf_state_t;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 8;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy vector: one set port, one clear port, sync clear and two
// combinational lookups. A set and a clear to the same entry leave it busy.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          setEn,
    input  logic [AW-1:0] setAddr,
    input  logic          clrEn,
    input  logic [AW-1:0] clrAddr,
    input  logic [AW-1:0] lookAddr1,
    input  logic [AW-1:0] lookAddr2,
    output logic          lookBusy1,
    output logic          lookBusy2
);

    logic [DEPTH-1:0] busyVec;

    // Set is applied after clear so the newest producer wins.
    always_ff @(posedge clk) begin
        if (clear) begin
            busyVec <= '0;
        end else begin
            if (clrEn) busyVec[clrAddr] <= 1'b0;
            if (setEn) busyVec[setAddr] <= 1'b1;
        end
    end

    assign lookBusy1 = busyVec[lookAddr1];
    assign lookBusy2 = busyVec[lookAddr2];

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, optional
// zero register, write-to-read bypass, busy scoreboard and post-reset clearing.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [AW-1:0]    WriteReg,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             Reserve,
    input  logic [AW-1:0]    ReserveReg,
    input  logic [AW-1:0]    ReadReg1,
    input  logic [AW-1:0]    ReadReg2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             Busy1,
    output logic             Busy2,
    output logic             ready
);

    logic [WIDTH-1:0] regs [DEPTH];
    rf_state_t        state;
    logic [AW-1:0]    clrCnt;

    logic             wrAllowed;
    logic             rsvAllowed;
    logic             sbBusy   [2];
    logic [AW-1:0]    rdAddr   [2];
    logic [WIDTH-1:0] rdData   [2];
    logic             rdBusy   [2];

    // Sweep every entry to zero after reset, then hand the file to the pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= INIT;
            clrCnt <= '0;
            ready  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clrCnt <= clrCnt + 1'b1;
                    if (clrCnt == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    assign wrAllowed  = RegWrite && (state == RUN) &&
                        !((ZERO_REG != 0) && (WriteReg == '0));
    assign rsvAllowed = Reserve && (state == RUN) &&
                        !((ZERO_REG != 0) && (ReserveReg == '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT)
                regs[clrCnt] <= '0;
            else if (wrAllowed)
                regs[WriteReg] <= WriteData;
        end
    end

    rf_scoreboard #(.DEPTH(DEPTH)) scoreboard (
        .clk       (clk),
        .clear     (reset),
        .setEn     (rsvAllowed),
        .setAddr   (ReserveReg),
        .clrEn     (wrAllowed),
        .clrAddr   (WriteReg),
        .lookAddr1 (ReadReg1),
        .lookAddr2 (ReadReg2),
        .lookBusy1 (sbBusy[0]),
        .lookBusy2 (sbBusy[1])
    );

    assign rdAddr[0] = ReadReg1;
    assign rdAddr[1] = ReadReg2;

    // A same-cycle write forwards its data and its busy clear, unless a
    // reserve to the same register re-marks it busy in that cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdData[p] = '0;
            rdBusy[p] = 1'b0;
            if (ready && !((ZERO_REG != 0) && (rdAddr[p] == '0))) begin
                if ((BYPASS != 0) && wrAllowed && (WriteReg == rdAddr[p])) begin
                    rdData[p] = WriteData;
                    rdBusy[p] = rsvAllowed && (ReserveReg == rdAddr[p]);
                end else begin
                    rdData[p] = regs[rdAddr[p]];
                    rdBusy[p] = sbBusy[p];
                end
            end
        end
    end

    assign ReadData1 = rdData[0];
    assign ReadData2 = rdData[1];
    assign Busy1     = rdBusy[0];
    assign Busy2     = rdBusy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised bench for regfile_sb against a behavioural model, with a
// non-bypass twin and two size-sweep instances.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rw, rsv;
    logic [2:0]  wr, rsvR, rr1, rr2;
    logic [31:0] wd;
    logic [31:0] rd1, rd2, nrd1, nrd2;
    logic        b1, b2, nb1, nb2, rdy, nrdy;

    logic        aRw;
    logic [1:0]  aWr, aRr;
    logic [15:0] aWd, aRd1, aRd2;
    logic        aB1, aB2, aRdy;

    logic        bRw;
    logic [4:0]  bWr, bRr;
    logic [63:0] bWd, bRd1, bRd2;
    logic        bB1, bB2, bRdy;

    regfile_sb dut (
        .clk(clk), .reset(reset), .RegWrite(rw), .WriteReg(wr), .WriteData(wd),
        .Reserve(rsv), .ReserveReg(rsvR), .ReadReg1(rr1), .ReadReg2(rr2),
        .ReadData1(rd1), .ReadData2(rd2), .Busy1(b1), .Busy2(b2), .ready(rdy)
    );

    regfile_sb #(.BYPASS(0)) dutNoByp (
        .clk(clk), .reset(reset), .RegWrite(rw), .WriteReg(wr), .WriteData(wd),
        .Reserve(rsv), .ReserveReg(rsvR), .ReadReg1(rr1), .ReadReg2(rr2),
        .ReadData1(nrd1), .ReadData2(nrd2), .Busy1(nb1), .Busy2(nb2), .ready(nrdy)
    );

    regfile_sb #(.WIDTH(16), .DEPTH(4)) dutSmall (
        .clk(clk), .reset(reset), .RegWrite(aRw), .WriteReg(aWr), .WriteData(aWd),
        .Reserve(1'b0), .ReserveReg(2'd0), .ReadReg1(aRr), .ReadReg2(aRr),
        .ReadData1(aRd1), .ReadData2(aRd2), .Busy1(aB1), .Busy2(aB2), .ready(aRdy)
    );

    regfile_sb #(.WIDTH(64), .DEPTH(32)) dutLarge (
        .clk(clk), .reset(reset), .RegWrite(bRw), .WriteReg(bWr), .WriteData(bWd),
        .Reserve(1'b0), .ReserveReg(5'd0), .ReadReg1(bRr), .ReadReg2(bRr),
        .ReadData1(bRd1), .ReadData2(bRd2), .Busy1(bB1), .Busy2(bB2), .ready(bRdy)
    );

    int vecCnt = 0;
    int errCnt = 0;

    logic [31:0] mReg  [8];
    logic        mBusy [8];
    int          mSince;
    bit          mReady;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural view: the file is unusable until DEPTH clean edges have
    // passed since reset, after which every register holds zero.
    task automatic modelEdge();
        if (reset) begin
            for (int i = 0; i < 8; i++) mBusy[i] = 1'b0;
            mSince = 0;
            mReady = 1'b0;
        end else if (!mReady) begin
            mSince++;
            if (mSince == 8) begin
                mReady = 1'b1;
                for (int i = 0; i < 8; i++) mReg[i] = '0;
            end
        end else begin
            if (rw && wr != 0) begin
                mReg[wr]  = wd;
                mBusy[wr] = 1'b0;
            end
            if (rsv && rsvR != 0) mBusy[rsvR] = 1'b1;
        end
    endtask

    task automatic expRead(input logic [2:0] a, input bit byp,
                           output logic [31:0] d, output logic b);
        if (!mReady || a == 0) begin
            d = '0;
            b = 1'b0;
        end else if (byp && rw && wr == a) begin
            d = wd;
            b = rsv && (rsvR == a);
        end else begin
            d = mReg[a];
            b = mBusy[a];
        end
    endtask

    task automatic checkMain();
        logic [31:0] ed;
        logic        eb;
        expRead(rr1, 1'b1, ed, eb); chk("rd1", rd1, ed);   chk("busy1", b1, eb);
        expRead(rr2, 1'b1, ed, eb); chk("rd2", rd2, ed);   chk("busy2", b2, eb);
        expRead(rr1, 1'b0, ed, eb); chk("nb_rd1", nrd1, ed); chk("nb_busy1", nb1, eb);
        expRead(rr2, 1'b0, ed, eb); chk("nb_rd2", nrd2, ed); chk("nb_busy2", nb2, eb);
        chk("ready", rdy, mReady);
        chk("nb_ready", nrdy, mReady);
    endtask

    task automatic cyc();
        #1;
        checkMain();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        rw = 0; rsv = 0; wr = 0; rsvR = 0; rr1 = 0; rr2 = 0; wd = 0;
        aRw = 0; aWr = 0; aRr = 0; aWd = 0;
        bRw = 0; bWr = 0; bRr = 0; bWd = 0;
        for (int i = 0; i < 8; i++) begin
            mReg[i]  = '0;
            mBusy[i] = 1'b0;
        end
        mSince = 0;
        mReady = 1'b0;
        @(posedge clk);
        modelEdge();
        #1;
        cyc();
        reset = 1'b0;

        // Clearing sequence; writes issued to reg3 meanwhile must be dropped.
        for (int k = 1; k <= 32; k++) begin
            rw = (k <= 8); wr = 3'd3; wd = 32'hCAFE; rr1 = 3'd3; rr2 = 3'd1;
            cyc();
            chk("small_ready", aRdy, (k >= 4));
            chk("large_ready", bRdy, (k >= 32));
        end
        rw = 0;
        #1;
        chk("init_write_lost", rd1, 32'h0);

        // Size sweep: all-ones through the top address.
        aRr = 2'd3; bRr = 5'd31;
        #1;
        chk("small_top_clr", aRd1, 16'h0);
        chk("large_top_clr", bRd1, 64'h0);
        aRw = 1; aWr = 2'd3; aWd = 16'hFFFF;
        bRw = 1; bWr = 5'd31; bWd = '1;
        #1;
        chk("small_top_byp", aRd1, 16'hFFFF);
        chk("large_top_byp", bRd1, {64{1'b1}});
        @(posedge clk);
        #1;
        aRw = 0; bRw = 0;
        #1;
        chk("small_top_rd1", aRd1, 16'hFFFF);
        chk("small_top_rd2", aRd2, 16'hFFFF);
        chk("large_top_rd1", bRd1, {64{1'b1}});
        chk("large_top_rd2", bRd2, {64{1'b1}});
        chk("small_busy", {aB1, aB2}, 2'b00);
        chk("large_busy", {bB1, bB2}, 2'b00);

        // Same-cycle write/read of reg5 on both variants.
        rw = 1; wr = 3'd5; wd = 32'hDEADBEEF; rr1 = 3'd5;
        #1;
        chk("byp_dead", rd1, 32'hDEADBEEF);
        chk("nobyp_dead", nrd1, 32'h0);
        cyc();
        rw = 0;
        #1;
        chk("nobyp_dead_next", nrd1, 32'hDEADBEEF);

        // Zero register ignores writes and reserves.
        rw = 1; wr = 3'd0; wd = 32'h1234; rsv = 1; rsvR = 3'd0; rr1 = 0; rr2 = 0;
        cyc();
        rw = 0; rsv = 0;
        #1;
        chk("zero_rd", {rd1, rd2}, 64'h0);
        chk("zero_busy", {b1, b2, nb1, nb2}, 4'b0);
        cyc();

        // Scoreboard set, bypassed clear, and set-over-clear.
        rsv = 1; rsvR = 3'd2; rr1 = 3'd2;
        cyc();
        rsv = 0;
        #1;
        chk("rsv_busy", b1, 1'b1);
        rw = 1; wr = 3'd2; wd = 32'hA5;
        #1;
        chk("wr_clr_byp", b1, 1'b0);
        chk("wr_clr_nobyp", nb1, 1'b1);
        cyc();
        rw = 0;
        #1;
        chk("wr_clr_after", b1, 1'b0);
        chk("wr_data_after", rd1, 32'hA5);
        rw = 1; wr = 3'd4; wd = 32'hA5; rsv = 1; rsvR = 3'd4; rr1 = 3'd4;
        cyc();
        rw = 0; rsv = 0;
        #1;
        chk("rsv_wr_data", rd1, 32'hA5);
        chk("rsv_wr_busy", b1, 1'b1);

        // Reset pulse in RUN wipes busy state and later the data.
        rw = 1; wr = 3'd6; wd = 32'h77;
        cyc();
        rw = 0; rsv = 1; rsvR = 3'd6; rr1 = 3'd6;
        cyc();
        rsv = 0;
        #1;
        chk("r6_pre_data", rd1, 32'h77);
        chk("r6_pre_busy", b1, 1'b1);
        reset = 1;
        cyc();
        reset = 0;
        #1;
        chk("r6_rst_ready", rdy, 1'b0);
        chk("r6_rst_busy", b1, 1'b0);
        for (int k = 0; k < 8; k++) cyc();
        #1;
        chk("r6_post_ready", rdy, 1'b1);
        chk("r6_post_data", rd1, 32'h0);
        chk("r6_post_busy", b1, 1'b0);

        // Random traffic, occasionally resetting.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            rw    = 1'($urandom_range(0, 1));
            rsv   = 1'($urandom_range(0, 1));
            wr    = 3'($urandom_range(0, 7));
            rsvR  = 3'($urandom_range(0, 7));
            rr1   = 3'($urandom_range(0, 7));
            rr2   = 3'($urandom_range(0, 7));
            wd    = $urandom;
            if ($urandom_range(0, 3) == 0) rr1 = wr;
            if ($urandom_range(0, 3) == 0) rsvR = wr;
            cyc();
        end
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
